// File: rtl/multi_hex_store.sv
// -----------------------------------------------------------------------------
// multi_hex_store
//
// Multi-channel hex-digit entry store. NUM_CH independent channels each hold
// up to DIGITS hex digits. Shared keypad commands (enter, backspace, clear,
// commit) are edge-detected and steered to one channel by ch_sel. A full
// channel can be committed (locked); a locked channel only responds to clear.
// Channel 0 is the guess and channel 1 the secret in the game; the packed
// outputs feed the compare/score logic and the seven-segment display mux.
//
// Parameters
//   NUM_CH   : number of channels (>= 1)
//   DIGITS   : hex digits per channel (>= 1)
//   CH_SEL_W : width of ch_sel, 2**CH_SEL_W >= NUM_CH
//   WRAP     : 0 = enter on a full channel is ignored,
//              1 = enter on a full channel restarts it with the new digit
//
// Ports
//   clk         : system clock
//   reset       : asynchronous active-low reset
//   hex_in      : digit value from the keypad decoder
//   enter       : debounced level, stores hex_in on its rising edge
//   backspace   : debounced level, removes the last digit on its rising edge
//   clear       : debounced level, empties and unlocks the selected channel
//   commit      : debounced level, locks the selected channel if it is full
//   ch_sel      : target channel for all commands (out-of-range = ignored)
//   digits      : channel c word at [c*DIGITS*4 +: DIGITS*4], first digit
//                 entered sits in the most-significant nibble
//   count       : channel c digit count at [c*CNT_W +: CNT_W]
//   full        : bit c set when channel c holds DIGITS digits
//   locked      : bit c set when channel c is committed
//   commit_done : one-cycle pulse after a successful commit
// -----------------------------------------------------------------------------
module multi_hex_store #(
  parameter  int NUM_CH   = 2,
  parameter  int DIGITS   = 4,
  parameter  int CH_SEL_W = 1,
  parameter  int WRAP     = 0,
  localparam int CNT_W    = $clog2(DIGITS + 1)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [3:0]                   hex_in,
  input  logic                         enter,
  input  logic                         backspace,
  input  logic                         clear,
  input  logic                         commit,
  input  logic [CH_SEL_W-1:0]          ch_sel,
  output logic [NUM_CH*DIGITS*4-1:0]   digits,
  output logic [NUM_CH*CNT_W-1:0]      count,
  output logic [NUM_CH-1:0]            full,
  output logic [NUM_CH-1:0]            locked,
  output logic                         commit_done
);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DIGITS);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // ---------------------------------------------------------------------------
  // Edge detection
  // ---------------------------------------------------------------------------
  // r_armed stays low for the first clock after reset so that a level already
  // high when reset releases only loads the history registers and never acts.
  logic r_enter_d;
  logic r_backspace_d;
  logic r_clear_d;
  logic r_commit_d;
  logic r_armed;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_enter_d     <= 1'b0;
      r_backspace_d <= 1'b0;
      r_clear_d     <= 1'b0;
      r_commit_d    <= 1'b0;
      r_armed       <= 1'b0;
    end else begin
      r_enter_d     <= enter;
      r_backspace_d <= backspace;
      r_clear_d     <= clear;
      r_commit_d    <= commit;
      r_armed       <= 1'b1;
    end
  end

  logic w_enter_edge;
  logic w_backspace_edge;
  logic w_clear_edge;
  logic w_commit_edge;

  assign w_enter_edge     = r_armed & enter     & ~r_enter_d;
  assign w_backspace_edge = r_armed & backspace & ~r_backspace_d;
  assign w_clear_edge     = r_armed & clear     & ~r_clear_d;
  assign w_commit_edge    = r_armed & commit    & ~r_commit_d;

  // ---------------------------------------------------------------------------
  // Command arbitration: clear > backspace > enter > commit.
  // The winner is chosen on edges alone, so a higher-priority command that
  // turns out to be a no-op (e.g. backspace on an empty channel) still
  // swallows the lower-priority ones in that cycle.
  // ---------------------------------------------------------------------------
  logic w_sel_valid;
  logic w_do_clear;
  logic w_do_backspace;
  logic w_do_enter;
  logic w_do_commit;

  assign w_sel_valid    = (32'(ch_sel) < 32'(NUM_CH));
  assign w_do_clear     = w_sel_valid & w_clear_edge;
  assign w_do_backspace = w_sel_valid & w_backspace_edge & ~w_clear_edge;
  assign w_do_enter     = w_sel_valid & w_enter_edge & ~w_clear_edge
                          & ~w_backspace_edge;
  assign w_do_commit    = w_sel_valid & w_commit_edge & ~w_clear_edge
                          & ~w_backspace_edge & ~w_enter_edge;

  // Per-channel "this commit succeeded" flags, ORed into the pulse register.
  logic [NUM_CH-1:0] w_commit_vec;

  // ---------------------------------------------------------------------------
  // Channels
  // ---------------------------------------------------------------------------
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [DIGITS*4-1:0] r_word;
    logic [DIGITS*4-1:0] w_word_nxt;
    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    w_cnt_nxt;
    logic                r_lock;
    logic                w_lock_nxt;
    logic                w_hit;
    logic                w_commit_ok;

    assign w_hit = (ch_sel == CH_SEL_W'(c));

    // NOTE: every signal gets a default before any branch; a path that leaves
    // a combinational output unassigned would infer a latch.
    always_comb begin
      w_word_nxt  = r_word;
      w_cnt_nxt   = r_cnt;
      w_lock_nxt  = r_lock;
      w_commit_ok = 1'b0;

      if (w_hit) begin
        if (w_do_clear) begin
          w_word_nxt = '0;
          w_cnt_nxt  = '0;
          w_lock_nxt = 1'b0;
        end else if (!r_lock) begin
          if (w_do_backspace) begin
            if (r_cnt != '0) begin
              // The vacated nibble is the one last written: index DIGITS-cnt.
              for (int i = 0; i < DIGITS; i++) begin
                if (i == DIGITS - int'(r_cnt)) begin
                  w_word_nxt[i*4 +: 4] = 4'h0;
                end
              end
              w_cnt_nxt = r_cnt - CNT_ONE;
            end
          end else if (w_do_enter) begin
            if (r_cnt < CNT_FULL) begin
              // Digits fill from the top nibble downwards.
              for (int i = 0; i < DIGITS; i++) begin
                if (i == DIGITS - 1 - int'(r_cnt)) begin
                  w_word_nxt[i*4 +: 4] = hex_in;
                end
              end
              w_cnt_nxt = r_cnt + CNT_ONE;
            end else if (WRAP != 0) begin
              w_word_nxt                     = '0;
              w_word_nxt[DIGITS*4-1 -: 4]    = hex_in;
              w_cnt_nxt                      = CNT_ONE;
            end
          end else if (w_do_commit) begin
            if (r_cnt == CNT_FULL) begin
              w_lock_nxt  = 1'b1;
              w_commit_ok = 1'b1;
            end
          end
        end
      end
    end

    // NOTE: the digit words are a handful of flops, not a RAM, so they take
    // the asynchronous reset like the rest of the state.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        r_word <= '0;
        r_cnt  <= '0;
        r_lock <= 1'b0;
      end else begin
        r_word <= w_word_nxt;
        r_cnt  <= w_cnt_nxt;
        r_lock <= w_lock_nxt;
      end
    end

    assign digits[c*DIGITS*4 +: DIGITS*4] = r_word;
    assign count[c*CNT_W +: CNT_W]        = r_cnt;
    assign full[c]                        = (r_cnt == CNT_FULL);
    assign locked[c]                      = r_lock;
    assign w_commit_vec[c]                = w_commit_ok;
  end

  // ---------------------------------------------------------------------------
  // Commit pulse: registered, so it appears together with the locked bit.
  // ---------------------------------------------------------------------------
  logic r_commit_done;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_commit_done <= 1'b0;
    end else begin
      r_commit_done <= |w_commit_vec;
    end
  end

  assign commit_done = r_commit_done;

endmodule

// File: doc/multi_hex_store.md
Name: multi_hex_store

Overview:
Parametrised multi-channel hex-digit entry store. It replaces the fixed two-slot, four-digit guess/set storage. NUM_CH independent channels each hold DIGITS hex digits, and a channel select steers shared keypad input to one channel. Compared with the two-slot store, it adds edge-detected enter, backspace, per-channel clear, commit/lock, saturate-or-wrap mode and full flags. It feeds the compare/score logic and the seven-segment display mux.

Parameters:
NUM_CH, 2, number of independent digit channels (min 1); channel 0 = guess, channel 1 = secret set in the game
DIGITS, 4, hex digits per channel (min 1)
CH_SEL_W, 1, width of ch_sel; must satisfy 2**CH_SEL_W >= NUM_CH
WRAP, 0, 0 = enter ignored when channel full; 1 = enter on full channel clears channel and writes digit as first entry
CNT_W (localparam), clog2(DIGITS+1), width of per-channel digit count

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
hex_in  input  4  digit value from keypad decoder
enter  input  1  debounced level; stores hex_in on rising edge
backspace  input  1  debounced level; removes last digit on rising edge
clear  input  1  debounced level; empties and unlocks selected channel on rising edge
commit  input  1  debounced level; locks selected channel on rising edge if full
ch_sel  input  CH_SEL_W  target channel for all four commands
digits  output  NUM_CH*DIGITS*4  channel c word at [c*DIGITS*4 +: DIGITS*4]; first-entered digit in most-significant nibble
count  output  NUM_CH*CNT_W  channel c digit count at [c*CNT_W +: CNT_W]
full  output  NUM_CH  bit c = (count of c == DIGITS)
locked  output  NUM_CH  bit c = channel c committed
commit_done  output  1  one-cycle pulse when a commit succeeds

Behaviour:
- Reset (async assert, sync-safe release): all digits 0, all counts 0, full 0, locked 0, commit_done 0, and edge-detect history registers 0. A level held high through reset release does not act.
- Edge detect: each command is registered once. The action is taken in the cycle where input=1 and the registered copy=0. The state update is visible on the next clk edge (1-cycle latency). Holding a level repeats nothing.
- ch_sel >= NUM_CH: all commands ignored, with no state change and no pulse.
- Priority when several edges land in the same cycle: clear > backspace > enter > commit. Only the highest-priority command executes; the others are dropped and are not queued.
- enter, channel not locked, count < DIGITS: write hex_in to nibble index (DIGITS-1-count) and increment count.
- enter, count == DIGITS, WRAP=0: no change.
- enter, count == DIGITS, WRAP=1: zero all nibbles, write hex_in to the top nibble, set count=1.
- backspace, not locked, count > 0: decrement count and zero the nibble just vacated. If count == 0, no change.
- clear: zero the channel's digits and count, clear locked. clear works on a locked channel.
- commit, not locked, count == DIGITS: set locked and pulse commit_done high for exactly one cycle. Otherwise no change and no pulse.
- Locked channel: enter, backspace and commit are ignored; only clear or reset affects it.
- Non-selected channels never change.
- full and locked are registered state or a direct decode of registered count; no combinational path from inputs to outputs.
- Reset asserted mid-entry: immediate clear of all channels regardless of clk.

Test Plan:
- Default params: reset, ch_sel=0, enter edges with hex_in=A,B,C,D -> digits[15:0]=16'hABCD, count0=4, full=2'b01, channel 1 word=0.
- Enter held high for 10 cycles with hex_in=5 -> exactly one digit stored, count0=1, digits[15:0]=16'h5000.
- Channel 0 full, WRAP=0: enter with hex_in=7 -> digits unchanged at 16'hABCD. Rebuild with WRAP=1: same stimulus -> 16'h7000, count0=1.
- Entries 1,2,3 then backspace -> 16'h1200, count=2. Backspace ×3 more -> 0, count=0, no underflow.
- ch_sel=1, enter 9,8,7,6, commit -> commit_done high one cycle, locked=2'b10. Then enter and backspace -> digits[31:16] stays 16'h9876. Then clear -> 0, locked=0.
- Simultaneous clear+enter edges on partially filled channel -> channel empty, count 0. Assert reset mid-entry asynchronously -> all outputs 0 before the next clk edge. Commit on count=3 -> no pulse, not locked.
